// File: rtl/dic_time_datapath.sv
// Dictation-clock datapath: mm:ss BCD time counter, alarm register, match/ring logic, display digits.
// Optional feature macro DIC_ALARM_FLASH_EN: blank the display on odd seconds while the alarm rings.
module dic_time_datapath #(
  parameter int unsigned RING_SECS = 10,
  parameter logic [3:0]  BLANK     = 4'hF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       oneSecStrb,
  input  logic [7:0] rx_data,
  input  logic       dicRun,
  input  logic       dicLdMTens,
  input  logic       dicLdMOnes,
  input  logic       dicLdSTens,
  input  logic       dicLdSOnes,
  input  logic       dicAMTens,
  input  logic       dicAMOnes,
  input  logic       dicASTens,
  input  logic       dicASOnes,
  input  logic       dicDspMtens,
  input  logic       dicDspMones,
  input  logic       dicDspStens,
  input  logic       dicDspSones,
  input  logic       dicStrMtens,
  input  logic       dicStrMones,
  input  logic       dicStrStens,
  input  logic       dicStrSones,
  input  logic       alarm_ena,
  output logic [3:0] di_Mtens,
  output logic [3:0] di_Mones,
  output logic [3:0] di_Stens,
  output logic [3:0] di_Sones,
  output logic       rollover,
  output logic       alarm_ring
);

  localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);

  logic [3:0] mt_q, mo_q, st_q, so_q, mt_d, mo_d, st_d, so_d;
  logic [3:0] amt_q, amo_q, ast_q, aso_q, amt_d, amo_d, ast_d, aso_d;
  logic [3:0] dmt_q, dmo_q, dst_q, dso_q, dmt_d, dmo_d, dst_d, dso_d;
  logic       roll_q, roll_d;
  logic       match_q, match_d, match_dly_q;
  logic       ring_q, ring_d;
  logic [7:0] cnt_q, cnt_d;
  logic       any_ld, tick, rise, flash;

  function automatic logic [3:0] pick_digit(input logic str, input logic dsp,
                                            input logic [3:0] alm, input logic [3:0] tim);
    logic [3:0] r;
    if (str) begin
      r = alm;
    end else if (dsp) begin
      r = tim;
    end else begin
      r = BLANK;
    end
    return r;
  endfunction

  assign any_ld = dicLdMTens | dicLdMOnes | dicLdSTens | dicLdSOnes;
  // A load in the same cycle as a strobe swallows that second.
  assign tick   = oneSecStrb & dicRun & ~any_ld;
  assign rise   = match_q & ~match_dly_q;

`ifdef DIC_ALARM_FLASH_EN
  assign flash = ring_q & so_q[0];
`else
  assign flash = 1'b0;
`endif

  // Time counter next state: increment with carry chain, or raw digit loads.
  always_comb begin
    mt_d   = mt_q;
    mo_d   = mo_q;
    st_d   = st_q;
    so_d   = so_q;
    roll_d = 1'b0;
    if (tick) begin
      // ">=" so out-of-range loaded digits wrap on their next carry.
      if (so_q >= 4'd9) begin
        so_d = 4'd0;
        if (st_q >= 4'd5) begin
          st_d = 4'd0;
          if (mo_q >= 4'd9) begin
            mo_d = 4'd0;
            if (mt_q >= 4'd5) begin
              mt_d   = 4'd0;
              roll_d = 1'b1;
            end else begin
              mt_d = mt_q + 4'd1;
            end
          end else begin
            mo_d = mo_q + 4'd1;
          end
        end else begin
          st_d = st_q + 4'd1;
        end
      end else begin
        so_d = so_q + 4'd1;
      end
    end else begin
      if (dicLdMTens) mt_d = rx_data[3:0]; else mt_d = mt_q;
      if (dicLdMOnes) mo_d = rx_data[3:0]; else mo_d = mo_q;
      if (dicLdSTens) st_d = rx_data[3:0]; else st_d = st_q;
      if (dicLdSOnes) so_d = rx_data[3:0]; else so_d = so_q;
    end
  end

  // Alarm register next state.
  always_comb begin
    amt_d = amt_q;
    amo_d = amo_q;
    ast_d = ast_q;
    aso_d = aso_q;
    if (dicAMTens) amt_d = rx_data[3:0]; else amt_d = amt_q;
    if (dicAMOnes) amo_d = rx_data[3:0]; else amo_d = amo_q;
    if (dicASTens) ast_d = rx_data[3:0]; else ast_d = ast_q;
    if (dicASOnes) aso_d = rx_data[3:0]; else aso_d = aso_q;
  end

  // Match compare and ring state; disarming wins over everything.
  always_comb begin
    match_d = ({mt_q, mo_q, st_q, so_q} == {amt_q, amo_q, ast_q, aso_q});
    ring_d  = ring_q;
    cnt_d   = cnt_q;
    if (!alarm_ena) begin
      ring_d = 1'b0;
      cnt_d  = 8'd0;
    end else if (rise && dicRun) begin
      ring_d = 1'b1;
      cnt_d  = 8'd0;
    end else if (ring_q && oneSecStrb) begin
      if (cnt_q >= RING_LAST) begin
        ring_d = 1'b0;
        cnt_d  = 8'd0;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end else begin
      ring_d = ring_q;
      cnt_d  = cnt_q;
    end
  end

  // Display digit selection: alarm store overrides time display.
  always_comb begin
    dmt_d = pick_digit(dicStrMtens, dicDspMtens, amt_q, mt_q);
    dmo_d = pick_digit(dicStrMones, dicDspMones, amo_q, mo_q);
    dst_d = pick_digit(dicStrStens, dicDspStens, ast_q, st_q);
    dso_d = pick_digit(dicStrSones, dicDspSones, aso_q, so_q);
    if (flash) begin
      dmt_d = BLANK;
      dmo_d = BLANK;
      dst_d = BLANK;
      dso_d = BLANK;
    end else begin
      dmt_d = dmt_d;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      {mt_q, mo_q, st_q, so_q}     <= 16'd0;
      {amt_q, amo_q, ast_q, aso_q} <= 16'd0;
      {dmt_q, dmo_q, dst_q, dso_q} <= {BLANK, BLANK, BLANK, BLANK};
      roll_q      <= 1'b0;
      match_q     <= 1'b0;
      match_dly_q <= 1'b0;
      ring_q      <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      {mt_q, mo_q, st_q, so_q}     <= {mt_d, mo_d, st_d, so_d};
      {amt_q, amo_q, ast_q, aso_q} <= {amt_d, amo_d, ast_d, aso_d};
      {dmt_q, dmo_q, dst_q, dso_q} <= {dmt_d, dmo_d, dst_d, dso_d};
      roll_q      <= roll_d;
      match_q     <= match_d;
      match_dly_q <= match_q;
      ring_q      <= ring_d;
      cnt_q       <= cnt_d;
    end
  end

  assign di_Mtens   = dmt_q;
  assign di_Mones   = dmo_q;
  assign di_Stens   = dst_q;
  assign di_Sones   = dso_q;
  assign rollover   = roll_q;
  assign alarm_ring = ring_q;

endmodule

// File: doc/dic_time_datapath.md
Name: dic_time_datapath

Overview:
- Datapath stage directly downstream of the dictation-clock control FSM.
- Consumes the FSM's run, load, alarm-load, display and alarm-store controls plus the received ASCII byte.
- Holds the mm:ss BCD time counter and the mm:ss alarm register, detects alarm match, and drives the ringing output.
- Produces the four registered display digits sent to the LED/UART display stage.

Parameters:
- RING_SECS, 10, number of one-second ticks the alarm rings before self-clearing (1..255)
- BLANK, 4'hF, digit code the display stage renders as blank

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- oneSecStrb  input  1  one-cycle pulse, once per second
- rx_data  input  8  ASCII byte from UART decoder; bits [3:0] are the digit value
- dicRun  input  1  counter advances on ticks when high
- dicLdMTens, dicLdMOnes, dicLdSTens, dicLdSOnes  input  1 each  load rx_data[3:0] into that time digit
- dicAMTens, dicAMOnes, dicASTens, dicASOnes  input  1 each  load rx_data[3:0] into that alarm digit
- dicDspMtens, dicDspMones, dicDspStens, dicDspSones  input  1 each  show time digit, else blank
- dicStrMtens, dicStrMones, dicStrStens, dicStrSones  input  1 each  show alarm digit (overrides Dsp)
- alarm_ena  input  1  alarm armed
- di_Mtens, di_Mones, di_Stens, di_Sones  output  4 each  registered display digits
- rollover  output  1  one-cycle pulse on 59:59 -> 00:00
- alarm_ring  output  1  alarm sounding

Behaviour:
- Reset: time = 00:00, alarm = 00:00, all di_* = BLANK, rollover = 0, alarm_ring = 0, ring counter = 0. Reset mid-ring or mid-load clears everything the same cycle it is sampled.
- Digit limits: Sones 0-9, Stens 0-5, Mones 0-9, Mtens 0-5.
- Increment on the clk edge where oneSecStrb=1, dicRun=1 and no dicLd* is asserted:
  - Sones+1.
  - A digit whose value is >= its limit wraps to 0 and carries into the next digit. An out-of-range loaded value (e.g. Stens=7) therefore wraps on its next carry.
  - 59:59 -> 00:00 with rollover=1 for exactly the following cycle.
- Time load: on any edge where dicLdX=1, digit X <= rx_data[3:0] with no range check.
  - If any dicLd* is high, that cycle's tick is dropped, not deferred.
  - Several dicLd* high together load the same value into each.
- Alarm load: dicAX=1 loads alarm digit X from rx_data[3:0]. Ticks are unaffected.
- Match:
  - Registered compare; match_q=1 the cycle after time equals the alarm value.
  - alarm_ring sets on the rising edge of match_q when alarm_ena=1 and dicRun=1.
  - Loading time equal to the alarm does not ring while dicRun=0.
- Ring:
  - While ringing, each oneSecStrb increments the ring counter.
  - alarm_ring clears when the counter reaches RING_SECS, or immediately (next edge) when alarm_ena=0. The counter then returns to 0.
  - A new match while ringing restarts the count.
- Display, per digit, registered with 1-cycle latency:
  - dicStrX=1 -> alarm digit
  - else dicDspX=1 -> time digit
  - else BLANK
- Display follows loaded or incremented values one cycle after the updating edge.

Optional Feature:
- DIC_ALARM_FLASH_EN defined: while alarm_ring=1, all four di_* are forced to BLANK when time Sones is odd, producing a 1 Hz flash. Normal output resumes the cycle after alarm_ring clears.
- Undefined: display is unaffected by ringing.

Test Plan:
- rst for 2 cycles, then dicRun=1 with 3 oneSecStrb pulses, Dsp all 1 -> di = 0,0,0,3; rollover never set.
- Load 5,9,5,8 via dicLdMTens..dicLdSOnes (rx_data 0x35,0x39,0x35,0x38), then 2 ticks -> 59:59 then 00:00; rollover high exactly 1 cycle after the second tick.
- Assert dicLdSOnes with rx_data=0x34 in the same cycle as oneSecStrb at time 00:07 -> Sones=4 (tick dropped), display 00:04 next cycle.
- Alarm 00:05, alarm_ena=1, run from 00:00 -> alarm_ring rises 2 cycles after the 5th tick; clears after 10 further ticks (RING_SECS=10). Dropping alarm_ena at the 3rd ring tick clears it on the next edge.
- Str all 1 with alarm 12:34, Dsp all 1 -> di = 1,2,3,4. Str=0, Dsp=4'b1000 only -> di = Mtens of time, F, F, F.
- DIC_ALARM_FLASH_EN defined, ringing at 00:05/00:06 -> di all F at 00:05, shows 0,0,0,6 at 00:06. Undefined -> never blank.
